// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART echo responder.
//   rx_state_t : receive FSM states
//   tx_state_t : transmit FSM states
//   DATA_BITS  : payload bits per 8N1 frame
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// Small byte FIFO holding received bytes until the transmitter echoes them.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers/count only)
//   push, din  : write request and byte
//   pop        : read request; dout shows the head byte combinationally
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
// A pop while empty is ignored.
// ---------------------------------------------------------------------------
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_BITS-1:0]     din,
   output logic [DATA_BITS-1:0]     dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 do_push;
   logic                 do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // When full, the slot freed by a same-cycle pop is the one being written.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_echo_responder.sv
// ---------------------------------------------------------------------------
// uart_echo_responder
// Far-end 8N1 UART that receives bytes on rx, buffers good ones in a FIFO and
// retransmits them in order on tx.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clk_div     : bit period minus 1 in clk cycles (>= 15, stable while busy)
//   tx_en       : allows the transmitter to take the next byte from the FIFO
//   rx / tx     : serial in / out, idle high; tx comes straight from a flop
//   rx_byte     : last good received byte, updated with rx_valid
//   rx_valid    : one-cycle pulse per good byte (also the FIFO push)
//   frame_err   : one-cycle pulse on a low stop bit
//   overflow    : one-cycle pulse when a good byte is dropped (FIFO full)
//   tx_done     : one-cycle pulse on the last cycle of each echoed stop bit
//   fifo_count  : FIFO occupancy
//   busy        : either FSM active or FIFO non-empty
// ---------------------------------------------------------------------------
module uart_echo_responder
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [CNT_W-1:0]              clk_div,
   input  logic                          tx_en,
   input  logic                          rx,
   output logic                          tx,
   output logic [DATA_BITS-1:0]          rx_byte,
   output logic                          rx_valid,
   output logic                          frame_err,
   output logic                          overflow,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);

   logic                 rx_sync_p0;
   logic                 rx_sync_p1;
   logic                 rxs;

   rx_state_t            rx_state;
   logic [CNT_W-1:0]     rx_cnt;
   logic [2:0]           rx_bit_idx;
   logic [DATA_BITS-1:0] rx_shreg;
   logic [CNT_W-1:0]     rx_half;
   logic                 rx_sample;

   tx_state_t            tx_state;
   logic [CNT_W-1:0]     tx_cnt;
   logic [2:0]           tx_bit_idx;
   logic [DATA_BITS-1:0] tx_shreg;
   logic                 tx_pop;
   logic                 tx_bit_end;

   logic [DATA_BITS-1:0] fifo_dout;
   logic                 fifo_full;
   logic                 fifo_empty;

   // Stage p0/p1: two-flop synchronizer on the asynchronous serial input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
      end else begin
         rx_sync_p0 <= rx;
         rx_sync_p1 <= rx_sync_p0;
      end
   end

   assign rxs       = rx_sync_p1;
   assign rx_half   = clk_div >> 1;
   assign rx_sample = (rx_state == RX_DATA) && (rx_cnt == clk_div);

   always_ff @(posedge clk) begin
      if (rx_sample) rx_shreg <= {rxs, rx_shreg[DATA_BITS-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_bit_idx <= '0;
         rx_byte    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rxs) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == rx_half) begin
                  // A high line at mid start bit was only a glitch.
                  rx_cnt     <= '0;
                  rx_bit_idx <= '0;
                  rx_state   <= rxs ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == clk_div) begin
                  rx_cnt <= '0;
                  if (rx_bit_idx == 3'(DATA_BITS-1)) rx_state <= RX_STOP;
                  else rx_bit_idx <= rx_bit_idx + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == clk_div) begin
                  rx_cnt <= '0;
                  if (rxs) begin
                     rx_byte  <= rx_shreg;
                     rx_valid <= 1'b1;
                     rx_state <= RX_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     rx_state  <= RX_WAIT_HIGH;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_WAIT_HIGH: begin
               // A held-low line (break) must not look like a new start bit.
               if (rxs) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_valid),
      .pop   (tx_pop),
      .din   (rx_byte),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign overflow   = rx_valid && fifo_full && !tx_pop;
   assign tx_pop     = (tx_state == TX_IDLE) && tx_en && !fifo_empty;
   assign tx_bit_end = (tx_cnt == clk_div);

   // The shift register keeps the next bit to send in bit 0.
   always_ff @(posedge clk) begin
      if (tx_pop) tx_shreg <= fifo_dout;
      else if (tx_bit_end && ((tx_state == TX_START) || (tx_state == TX_DATA)))
         tx_shreg <= {1'b0, tx_shreg[DATA_BITS-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state   <= TX_IDLE;
         tx_cnt     <= '0;
         tx_bit_idx <= '0;
         tx         <= 1'b1;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               tx <= 1'b1;
               if (tx_pop) begin
                  tx_cnt   <= '0;
                  tx       <= 1'b0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_bit_end) begin
                  tx_cnt     <= '0;
                  tx_bit_idx <= '0;
                  tx         <= tx_shreg[0];
                  tx_state   <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  if (tx_bit_idx == 3'(DATA_BITS-1)) begin
                     tx       <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx         <= tx_shreg[0];
                     tx_bit_idx <= tx_bit_idx + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               // Raised one cycle early so the pulse lands on the last stop cycle.
               if (tx_cnt == clk_div - 1'b1) tx_done <= 1'b1;
               if (tx_bit_end) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   assign busy = (rx_state != RX_IDLE) || (tx_state != TX_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_echo_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_echo_responder
// Directed bench for uart_echo_responder: drives 8N1 frames on rx, decodes
// the echoed frames on tx independently and compares against hand-written
// expectations.
// ---------------------------------------------------------------------------
module tb_uart_echo_responder;

   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 16;
   localparam int QUIET_MAX  = 40000;

   logic                        clk = 1'b0;
   logic                        rst = 1'b1;
   logic [CNT_W-1:0]            clk_div = 16'd867;
   logic                        tx_en = 1'b1;
   logic                        rx = 1'b1;
   logic                        tx;
   logic [7:0]                  rx_byte;
   logic                        rx_valid;
   logic                        frame_err;
   logic                        overflow;
   logic                        tx_done;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        busy;

   uart_echo_responder #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_div    (clk_div),
      .tx_en      (tx_en),
      .rx         (rx),
      .tx         (tx),
      .rx_byte    (rx_byte),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .tx_done    (tx_done),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int bc = 868;              // bit period in cycles = clk_div + 1

   always @(posedge clk) cyc <= cyc + 1;

   // Event log of the DUT's pulse outputs.
   logic [7:0] rxv_q[$];
   int         rxv_cyc[$];
   int         done_cyc[$];
   logic [7:0] ovf_q[$];
   int         n_ferr = 0;

   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_q.push_back(rx_byte);
         rxv_cyc.push_back(cyc);
      end
      if (frame_err) n_ferr++;
      if (overflow) ovf_q.push_back(rx_byte);
      if (tx_done) done_cyc.push_back(cyc);
   end

   // Independent decoder of the tx line; frames hit by reset are discarded.
   logic [7:0] echo_q[$];
   logic       echo_stop_q[$];
   int         fall_cyc[$];
   logic       dec_active = 1'b0;

   initial begin : tx_decode
      logic       prev;
      logic       abort;
      logic [7:0] d;
      logic       stp;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && prev && !tx) begin
            dec_active = 1'b1;
            fall_cyc.push_back(cyc);
            abort = 1'b0;
            repeat (bc / 2) begin @(negedge clk); if (rst) abort = 1'b1; end
            for (int i = 0; i < 8; i++) begin
               repeat (bc) begin @(negedge clk); if (rst) abort = 1'b1; end
               d[i] = tx;
            end
            repeat (bc) begin @(negedge clk); if (rst) abort = 1'b1; end
            stp = tx;
            if (!abort) begin
               echo_q.push_back(d);
               echo_stop_q.push_back(stp);
            end
            dec_active = 1'b0;
         end
         prev = tx;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (bc) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (bc) @(negedge clk);
      end
      rx = stop_bit;
      repeat (bc) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic wait_quiet(input string tag);
      int n;
      n = 0;
      while ((busy || dec_active) && n < QUIET_MAX) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_quiet"}, 32'(n < QUIET_MAX), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int r0, e0, f0, d0, fe0, o0;
      int n;

      // Reset values while rst is held.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_tx",         32'(tx),         32'd1);
      check_eq("rst_rx_byte",    32'(rx_byte),    32'd0);
      check_eq("rst_rx_valid",   32'(rx_valid),   32'd0);
      check_eq("rst_frame_err",  32'(frame_err),  32'd0);
      check_eq("rst_overflow",   32'(overflow),   32'd0);
      check_eq("rst_tx_done",    32'(tx_done),    32'd0);
      check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
      check_eq("rst_busy",       32'(busy),       32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single byte at 115200 baud from 100 MHz.
      r0 = rxv_q.size(); e0 = echo_q.size(); f0 = fall_cyc.size(); d0 = done_cyc.size();
      send_frame(8'h41, 1'b1);
      wait_quiet("s1");
      check_eq("s1_rxv_n",      32'(rxv_q.size() - r0),  32'd1);
      check_eq("s1_rx_byte",    32'(rxv_q[r0]),          32'h41);
      check_eq("s1_latency",    32'(fall_cyc[f0] - rxv_cyc[r0]), 32'd2);
      check_eq("s1_echo_n",     32'(echo_q.size() - e0), 32'd1);
      check_eq("s1_echo",       32'(echo_q[e0]),         32'h41);
      check_eq("s1_echo_stop",  32'(echo_stop_q[e0]),    32'd1);
      check_eq("s1_done_n",     32'(done_cyc.size() - d0), 32'd1);
      check_eq("s1_done_cyc",   32'(done_cyc[d0]),       32'(fall_cyc[f0] + 10 * bc - 1));
      check_eq("s1_fifo_count", 32'(fifo_count),         32'd0);

      // Short low glitch on rx is rejected at mid start bit.
      r0 = rxv_q.size(); fe0 = n_ferr; f0 = fall_cyc.size();
      rx = 1'b0;
      repeat (100) @(negedge clk);
      rx = 1'b1;
      check_eq("glitch_busy",    32'(busy), 32'd1);
      repeat (600) @(negedge clk);
      check_eq("glitch_idle",    32'(busy), 32'd0);
      check_eq("glitch_rxv_n",   32'(rxv_q.size() - r0), 32'd0);
      check_eq("glitch_ferr_n",  32'(n_ferr - fe0),      32'd0);
      check_eq("glitch_tx_n",    32'(fall_cyc.size() - f0), 32'd0);

      // Faster bit rate for the remaining scenarios.
      clk_div = 16'd63;
      bc = 64;
      repeat (4) @(negedge clk);

      // Three back-to-back bytes.
      r0 = rxv_q.size(); e0 = echo_q.size(); f0 = fall_cyc.size();
      d0 = done_cyc.size(); o0 = ovf_q.size();
      send_frame(8'h41, 1'b1);
      send_frame(8'h42, 1'b1);
      send_frame(8'h43, 1'b1);
      wait_quiet("s2");
      check_eq("s2_rxv_n",  32'(rxv_q.size() - r0),  32'd3);
      check_eq("s2_echo_n", 32'(echo_q.size() - e0), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check_eq("s2_rx_byte", 32'(rxv_q[r0 + i]),  32'(8'h41 + i));
         check_eq("s2_echo",    32'(echo_q[e0 + i]), 32'(8'h41 + i));
      end
      check_eq("s2_gap0",  32'(fall_cyc[f0 + 1] - done_cyc[d0]),     32'd2);
      check_eq("s2_gap1",  32'(fall_cyc[f0 + 2] - done_cyc[d0 + 1]), 32'd2);
      check_eq("s2_ovf_n", 32'(ovf_q.size() - o0), 32'd0);

      // Bad stop bit followed by a break, then a good byte.
      r0 = rxv_q.size(); e0 = echo_q.size(); f0 = fall_cyc.size(); fe0 = n_ferr;
      send_frame(8'h55, 1'b0);
      rx = 1'b0;
      repeat (2 * bc) @(negedge clk);
      rx = 1'b1;
      repeat (bc) @(negedge clk);
      check_eq("s3_ferr_n",  32'(n_ferr - fe0),          32'd1);
      check_eq("s3_rxv_n",   32'(rxv_q.size() - r0),     32'd0);
      check_eq("s3_tx_n",    32'(fall_cyc.size() - f0),  32'd0);
      check_eq("s3_fifo",    32'(fifo_count),            32'd0);
      check_eq("s3_idle",    32'(busy),                  32'd0);
      send_frame(8'h42, 1'b1);
      wait_quiet("s3");
      check_eq("s3_rx_byte", 32'(rxv_q[r0]),  32'h42);
      check_eq("s3_echo_n",  32'(echo_q.size() - e0), 32'd1);
      check_eq("s3_echo",    32'(echo_q[e0]), 32'h42);

      // Echo held off: five bytes into a four-deep FIFO.
      tx_en = 1'b0;
      r0 = rxv_q.size(); e0 = echo_q.size(); f0 = fall_cyc.size(); o0 = ovf_q.size();
      for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 1'b1);
      repeat (10) @(negedge clk);
      check_eq("s5_fifo_full", 32'(fifo_count),            32'd4);
      check_eq("s5_rxv_n",     32'(rxv_q.size() - r0),     32'd5);
      check_eq("s5_ovf_n",     32'(ovf_q.size() - o0),     32'd1);
      check_eq("s5_ovf_byte",  32'(ovf_q[o0]),             32'h14);
      check_eq("s5_tx_held",   32'(fall_cyc.size() - f0),  32'd0);
      tx_en = 1'b1;
      wait_quiet("s5");
      check_eq("s5_echo_n",    32'(echo_q.size() - e0), 32'd4);
      for (int i = 0; i < 4; i++)
         check_eq("s5_echo", 32'(echo_q[e0 + i]), 32'(8'h10 + i));
      check_eq("s5_fifo_empty", 32'(fifo_count), 32'd0);

      // Reset while transmitting with two bytes still queued.
      tx_en = 1'b0;
      f0 = fall_cyc.size();
      send_frame(8'h21, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h23, 1'b1);
      repeat (10) @(negedge clk);
      check_eq("s6_fifo3", 32'(fifo_count), 32'd3);
      tx_en = 1'b1;
      n = 0;
      while (fall_cyc.size() == f0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("s6_tx_start", 32'(n < 100), 32'd1);
      repeat (2 * bc) @(negedge clk);
      check_eq("s6_queued", 32'(fifo_count), 32'd2);
      rst = 1'b1;
      #1;
      check_eq("s6_rst_tx",   32'(tx),         32'd1);
      check_eq("s6_rst_fifo", 32'(fifo_count), 32'd0);
      check_eq("s6_rst_busy", 32'(busy),       32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      r0 = rxv_q.size(); e0 = echo_q.size();
      send_frame(8'h41, 1'b1);
      wait_quiet("s6");
      check_eq("s6_rx_byte", 32'(rxv_q[r0]),          32'h41);
      check_eq("s6_echo_n",  32'(echo_q.size() - e0), 32'd1);
      check_eq("s6_echo",    32'(echo_q[e0]),         32'h41);
      check_eq("s6_fifo",    32'(fifo_count),         32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
